// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and access legality check for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unsigned variants exist only for loads; alignment is checked per width.
   function automatic logic is_legal_access(input logic we, input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
      logic legal;
      case (funct3)
         F3_B:    legal = 1'b1;
         F3_H:    legal = ~addr_lo[0];
         F3_W:    legal = (addr_lo == 2'b00);
         F3_BU:   legal = ~we;
         F3_HU:   legal = ~we & ~addr_lo[0];
         default: legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extraction with extension and store merge into the old word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] old_word,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] shifted;

   assign shifted   = old_word >> {addr_lo, 3'b000};
   assign byte_lane = shifted[7:0];
   assign half_lane = addr_lo[1] ? old_word[31:16] : old_word[15:0];

   always_comb begin
      load_data = 32'd0;
      case (funct3)
         F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
         F3_BU:   load_data = {24'd0, byte_lane};
         F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
         F3_HU:   load_data = {16'd0, half_lane};
         F3_W:    load_data = old_word;
         default: load_data = 32'd0;
      endcase
   end

   always_comb begin
      merged_word = old_word;
      case (funct3)
         F3_B:    merged_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
         F3_H:    merged_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
         default: merged_word = store_data;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte-addressed RV32 accesses mapped onto a word memory,
// with read-modify-write for sub-word stores and trapping of bad accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int P_ADDR_WIDTH = 11,
   parameter int P_DATA_WIDTH = 32
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_req,
   input  logic                    i_we,
   input  logic [2:0]              i_funct3,
   input  logic [31:0]             i_addr,
   input  logic [P_DATA_WIDTH-1:0] i_wdata,
   output logic                    o_ready,
   output logic                    o_done,
   output logic                    o_err,
   output logic [P_DATA_WIDTH-1:0] o_rdata,
   output logic                    o_mem_we,
   output logic [P_ADDR_WIDTH-1:0] o_mem_addr,
   output logic [P_DATA_WIDTH-1:0] o_mem_wdata,
   input  logic [P_DATA_WIDTH-1:0] i_mem_rdata
);

   lsu_state_e                state_reg, state_next;
   logic [P_ADDR_WIDTH-1:0]   word_addr_reg;
   logic [1:0]                addr_lo_reg;
   logic [2:0]                funct3_reg;
   logic                      we_reg;
   logic                      err_reg;
   logic [P_DATA_WIDTH-1:0]   wdata_reg;
   logic [P_DATA_WIDTH-1:0]   word_reg;
   logic [P_DATA_WIDTH-1:0]   load_data;
   logic [P_DATA_WIDTH-1:0]   merged_word;
   logic                      accept;
   logic                      unused_addr_bits;

   assign accept = i_req && (state_reg == ST_IDLE);

   // Upper address bits are deliberately dropped so the word address wraps.
   assign unused_addr_bits = &{1'b0, i_addr[31:P_ADDR_WIDTH+2]};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         word_addr_reg <= '0;
         addr_lo_reg   <= 2'b00;
         funct3_reg    <= 3'b000;
         we_reg        <= 1'b0;
         err_reg       <= 1'b0;
         wdata_reg     <= '0;
         word_reg      <= '0;
      end else begin
         if (accept) begin
            word_addr_reg <= i_addr[P_ADDR_WIDTH+1:2];
            addr_lo_reg   <= i_addr[1:0];
            funct3_reg    <= i_funct3;
            we_reg        <= i_we;
            err_reg       <= ~is_legal_access(i_we, i_funct3, i_addr[1:0]);
            wdata_reg     <= i_wdata;
         end
         if (state_reg == ST_READ) begin
            word_reg <= i_mem_rdata;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               if (~is_legal_access(i_we, i_funct3, i_addr[1:0])) begin
                  state_next = ST_RESP;
               end else if (i_we && (i_funct3 == F3_W)) begin
                  state_next = ST_WRITE;
               end else begin
                  state_next = ST_READ;
               end
            end
         end
         ST_READ:  state_next = we_reg ? ST_WRITE : ST_RESP;
         ST_WRITE: state_next = ST_IDLE;
         ST_RESP:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   lsu_align u_align (
      .funct3      (funct3_reg),
      .addr_lo     (addr_lo_reg),
      .old_word    (word_reg),
      .store_data  (wdata_reg),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   // Every output is a decode of state plus request registers.
   assign o_ready     = (state_reg == ST_IDLE);
   assign o_done      = (state_reg == ST_WRITE) || (state_reg == ST_RESP);
   assign o_err       = (state_reg == ST_RESP) && err_reg;
   assign o_mem_we    = (state_reg == ST_WRITE);
   assign o_mem_addr  = word_addr_reg;
   assign o_mem_wdata = (state_reg == ST_WRITE) ? merged_word : '0;
   assign o_rdata     = ((state_reg == ST_RESP) && !err_reg) ? load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-memory model and a result scoreboard.
module tb_load_store_unit;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_req = 1'b0;
   logic        i_we = 1'b0;
   logic [2:0]  i_funct3 = 3'b000;
   logic [31:0] i_addr = 32'd0;
   logic [31:0] i_wdata = 32'd0;
   logic        o_ready, o_done, o_err, o_mem_we;
   logic [31:0] o_rdata, o_mem_wdata, i_mem_rdata;
   logic [10:0] o_mem_addr;

   logic [31:0] mem [0:2047];
   logic        ld_en = 1'b0;
   logic [10:0] ld_addr = 11'd0;
   logic [31:0] ld_data = 32'd0;
   int          we_count = 0;
   logic [10:0] last_wr_addr = 11'd0;

   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } exp_t;
   exp_t sb_q[$];

   always #5 i_clk = ~i_clk;

   load_store_unit #(.P_ADDR_WIDTH(11), .P_DATA_WIDTH(32)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req       (i_req),
      .i_we        (i_we),
      .i_funct3    (i_funct3),
      .i_addr      (i_addr),
      .i_wdata     (i_wdata),
      .o_ready     (o_ready),
      .o_done      (o_done),
      .o_err       (o_err),
      .o_rdata     (o_rdata),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .i_mem_rdata (i_mem_rdata)
   );

   assign i_mem_rdata = mem[o_mem_addr];

   always @(posedge i_clk) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end else if (o_mem_we) begin
         mem[o_mem_addr] <= o_mem_wdata;
         last_wr_addr    <= o_mem_addr;
         we_count        <= we_count + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [10:0] a, input logic [31:0] d);
      @(negedge i_clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge i_clk);
      #1 ld_en = 1'b0;
   endtask

   task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input int exp_lat, input int exp_writes);
      int   wc0;
      int   cyc;
      exp_t e;
      @(negedge i_clk);
      i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
      sb_q.push_back('{exp_err, exp_rdata, exp_lat});
      wc0 = we_count;
      @(posedge i_clk);
      #1 i_req = 1'b0;
      cyc = 1;
      @(negedge i_clk);
      check({tag, "_ready_low"}, {31'd0, o_ready}, 32'd0);
      while (!o_done && cyc < 10) begin
         @(negedge i_clk);
         cyc++;
      end
      check({tag, "_done_seen"}, {31'd0, o_done}, 32'd1);
      e = sb_q.pop_front();
      check({tag, "_latency"}, cyc, e.lat);
      check({tag, "_err"}, {31'd0, o_err}, {31'd0, e.err});
      check({tag, "_rdata"}, o_rdata, e.rdata);
      @(posedge i_clk);
      #1;
      check({tag, "_ready_back"}, {31'd0, o_ready}, 32'd1);
      check({tag, "_writes"}, we_count - wc0, exp_writes);
      $display("txn %s we=%0b f3=%0b addr=%h wdata=%h -> err=%0b rdata=%h lat=%0d",
               tag, we, f3, addr, wdata, e.err, e.rdata, cyc);
   endtask

   initial begin
      int   wc0;
      logic done_seen;

      // Reset state
      #2;
      check("rst_ready", {31'd0, o_ready}, 32'd1);
      check("rst_done", {31'd0, o_done}, 32'd0);
      check("rst_err", {31'd0, o_err}, 32'd0);
      check("rst_mem_we", {31'd0, o_mem_we}, 32'd0);
      check("rst_rdata", o_rdata, 32'd0);
      check("rst_mem_addr", {21'd0, o_mem_addr}, 32'd0);
      check("rst_mem_wdata", o_mem_wdata, 32'd0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;

      // SW then LW
      do_req("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 1, 1);
      check("sw_10_mem", mem[4], 32'hDEADBEEF);
      check("sw_10_waddr", {21'd0, last_wr_addr}, 32'd4);
      do_req("lw_10", 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF, 2, 0);

      // SB read-modify-write
      preload(11'd4, 32'h11223344);
      do_req("sb_12", 1'b1, 3'b000, 32'h12, 32'h000000AA, 1'b0, 32'd0, 2, 1);
      check("sb_12_mem", mem[4], 32'h11AA3344);

      // Signed vs unsigned byte load
      preload(11'd4, 32'h80000000);
      do_req("lb_13", 1'b0, 3'b000, 32'h13, 32'd0, 1'b0, 32'hFFFFFF80, 2, 0);
      do_req("lbu_13", 1'b0, 3'b100, 32'h13, 32'd0, 1'b0, 32'h00000080, 2, 0);

      // Misaligned accesses
      do_req("lh_11", 1'b0, 3'b001, 32'h11, 32'd0, 1'b1, 32'd0, 1, 0);
      do_req("sw_12", 1'b1, 3'b010, 32'h12, 32'h55555555, 1'b1, 32'd0, 1, 0);
      check("misalign_mem", mem[4], 32'h80000000);

      // Illegal funct3 values
      do_req("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'd0, 1'b1, 32'd0, 1, 0);
      do_req("st_f3_100", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 1'b1, 32'd0, 1, 0);
      check("illegal_mem", mem[4], 32'h80000000);

      // Halfword store and loads in the upper half
      preload(11'd4, 32'h11223344);
      do_req("sh_12", 1'b1, 3'b001, 32'h12, 32'h1234BEEF, 1'b0, 32'd0, 2, 1);
      check("sh_12_mem", mem[4], 32'hBEEF3344);
      do_req("lhu_12", 1'b0, 3'b101, 32'h12, 32'd0, 1'b0, 32'h0000BEEF, 2, 0);
      do_req("lh_12", 1'b0, 3'b001, 32'h12, 32'd0, 1'b0, 32'hFFFFBEEF, 2, 0);
      do_req("lb_11", 1'b0, 3'b000, 32'h11, 32'd0, 1'b0, 32'h00000033, 2, 0);

      // Word address wraps modulo 2^11
      do_req("sw_wrap", 1'b1, 3'b010, 32'h0000_2010, 32'hCAFEF00D, 1'b0, 32'd0, 1, 1);
      check("sw_wrap_waddr", {21'd0, last_wr_addr}, 32'd4);
      check("sw_wrap_mem", mem[4], 32'hCAFEF00D);

      // Reset during the READ phase of an SH
      preload(11'd8, 32'h12345678);
      wc0 = we_count;
      @(negedge i_clk);
      i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b001; i_addr = 32'h20; i_wdata = 32'h0000BEEF;
      @(posedge i_clk);
      #1 i_req = 1'b0;
      @(negedge i_clk);
      check("abort_in_read_we", {31'd0, o_mem_we}, 32'd0);
      check("abort_in_read_ready", {31'd0, o_ready}, 32'd0);
      i_rst = 1'b1;
      #1;
      check("abort_ready", {31'd0, o_ready}, 32'd1);
      check("abort_done", {31'd0, o_done}, 32'd0);
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      done_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         done_seen = done_seen | o_done | o_mem_we;
      end
      check("abort_no_done", {31'd0, done_seen}, 32'd0);
      check("abort_writes", we_count - wc0, 32'd0);
      check("abort_mem8", mem[8], 32'h12345678);
      $display("txn abort_sh_20 reset in READ -> writes=%0d mem8=%h", we_count - wc0, mem[8]);

      // Unit still works after the abort
      do_req("lhu_20", 1'b0, 3'b101, 32'h20, 32'd0, 1'b0, 32'h00005678, 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the RISC-V core's execute/memory stage and the word-addressable `data_memory`. It converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. Loads are sign- or zero-extended. Byte and halfword stores use a read-modify-write sequence, because `data_memory` has a single whole-word write enable. Misaligned and illegal accesses are trapped before they reach memory.

## Interface
- `P_ADDR_WIDTH`, 11, word-address width of `data_memory`.
- `P_DATA_WIDTH`, 32, data width; fixed at 32 for RV32.

Ports:
- `i_clk`  in  1  single clock; all state updates on rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_req`  in  1  access request from core.
- `i_we`  in  1  1 = store, 0 = load.
- `i_funct3`  in  3  RV32 width/sign code.
- `i_addr`  in  32  byte address.
- `i_wdata`  in  32  store data, right-aligned.
- `o_ready`  out  1  unit idle; a request is accepted when `i_req & o_ready`.
- `o_done`  out  1  one-cycle completion pulse.
- `o_err`  out  1  valid with `o_done`; access was misaligned or illegal.
- `o_rdata`  out  32  extended load data; valid with `o_done` on loads.
- `o_mem_we`  out  1  to `data_memory` `i_we`.
- `o_mem_addr`  out  P_ADDR_WIDTH  word address, `i_addr[P_ADDR_WIDTH+1:2]`.
- `o_mem_wdata`  out  32  to `data_memory` `i_wdata`.
- `i_mem_rdata`  in  32  from `data_memory` `o_rdata` (combinational read).

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - `o_ready`=1.
  - On accept, the unit latches the address, funct3, we and wdata.
  - Illegal or misaligned access goes to RESP with the error flag set.
  - Load or sub-word store goes to READ.
  - SW goes to WRITE.
- READ: drives the latched word address and captures `i_mem_rdata` into a word register.
  - Load: goes to RESP.
  - Store: goes to WRITE.
- WRITE:
  - `o_mem_we`=1 for exactly one cycle.
  - `o_mem_wdata` is the SW data, or the merged word for SB/SH.
  - SB replaces byte `addr[1:0]`; SH replaces halfword `addr[1]`.
  - `o_done`=1 in this state, then the unit returns to IDLE.
- RESP:
  - `o_done`=1; `o_err` is set as latched.
  - For a load, `o_rdata` is the extracted lane, extended.
  - The unit then returns to IDLE.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Any other value sets `o_err`.
- Alignment rules: halfword requires `addr[0]`=0; word requires `addr[1:0]`=0.
- Erroneous accesses never assert `o_mem_we`, and `o_rdata` is 0.
- Address bits above `P_ADDR_WIDTH+1` are ignored; the word address wraps modulo 2^P_ADDR_WIDTH.
- `i_req` while busy is ignored; the core must hold the request until `o_ready`.
- `o_mem_we` is only ever asserted in WRITE.

## Timing
- Reset state:
  - State is IDLE.
  - `o_done`, `o_err`, `o_mem_we` = 0.
  - `o_rdata` = 0; `o_mem_addr` and `o_mem_wdata` = 0.
  - `o_ready` = 1.
- Latency, counted from the accept cycle 0:
  - Load: `o_done` in cycle 2.
  - SW: write and `o_done` in cycle 1.
  - SB/SH: read in cycle 1, write and `o_done` in cycle 2.
  - Error: `o_done` in cycle 1.
- `o_ready` falls the cycle after accept. It rises in the cycle after `o_done`, so back-to-back requests see one request per 2–3 cycles.
- All outputs are registered or decoded from state. There is no combinational path from `i_req` to the memory ports.
- Reset asserted mid-sequence returns the unit to IDLE immediately:
  - A pending RMW write is dropped and memory is unchanged.
  - No `o_done` is issued for the aborted request.

## Structure
- Shared package `lsu_pkg` holds:
  - the state enum `lsu_state_e`;
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - helper function `is_legal_access(we, funct3, addr_lo)`.
- One combinational sub-module `lsu_align`:
  - load-lane extraction with extension;
  - store-lane merge (old word, new data, funct3, `addr[1:0]`) into the new word.
- The top level holds the FSM and request registers, and instantiates `lsu_align` once.

## Test plan
- SW 0xDEADBEEF at byte address 0x10, then LW at 0x10:
  - the write lands at word 4 in cycle 1;
  - the load returns 0xDEADBEEF with `o_done` in cycle 2.
- Word 4 = 0x11223344; SB 0xAA at 0x12:
  - READ then WRITE;
  - memory word 4 becomes 0x11AA3344;
  - `o_mem_we` is high exactly one cycle.
- LB at 0x13 and LBU at 0x13 on word 4 = 0x80000000:
  - LB returns 0xFFFFFF80;
  - LBU returns 0x00000080.
- LH at 0x11 and SW at 0x12:
  - both give `o_err`=1 with `o_done` in cycle 1;
  - `o_mem_we` never rises;
  - memory is unchanged.
- Illegal load funct3=011: `o_err`=1, `o_rdata`=0.
- Assert `i_rst` during the READ state of SH 0xBEEF at 0x20:
  - no write occurs;
  - no `o_done` pulse;
  - `o_ready`=1 after reset;
  - memory word 8 is unchanged.
